// File: rtl/exe_csr_unit_pkg.sv
// Shared decode constants and types for the CSR execute stage.
// Latency: n/a (package).
// Backpressure: n/a (package).
package exe_csr_unit_pkg;

  localparam logic [6:0] INST_TYPE_SYSTEM = 7'b1110011;

  // Zicsr funct3 encodings
  localparam logic [2:0] INST_CSRRW  = 3'b001;
  localparam logic [2:0] INST_CSRRS  = 3'b010;
  localparam logic [2:0] INST_CSRRC  = 3'b011;
  localparam logic [2:0] INST_CSRRWI = 3'b101;
  localparam logic [2:0] INST_CSRRSI = 3'b110;
  localparam logic [2:0] INST_CSRRCI = 3'b111;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // I-type view of a SYSTEM instruction
  typedef struct packed {
    logic [11:0] addr;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } csr_inst_t;

  // addr[11:10] == 2'b11 marks the read-only CSR space
  function automatic logic csr_is_ro(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/exe_csr_unit_csr_counter.sv
// Wide free-running counter with per-half software write (mcycle/minstret).
// Latency: write or increment visible on cnt_o the cycle after the edge.
// Backpressure: none; a write to either half suppresses the increment on that edge.
// Ports: clk_i/rst_n_i (sync active-low), inc_i, wr_lo_i, wr_hi_i, wdata_i, cnt_o.
module csr_counter #(
  parameter int CNT_WIDTH  = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  inc_i,
  input  logic                  wr_lo_i,
  input  logic                  wr_hi_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [CNT_WIDTH-1:0]  cnt_o
);

  localparam logic [CNT_WIDTH-1:0] LO_MASK = CNT_WIDTH'({DATA_WIDTH{1'b1}});

  logic [CNT_WIDTH-1:0] wdata_ext;
  logic [CNT_WIDTH-1:0] cnt_wr;

  assign wdata_ext = CNT_WIDTH'(wdata_i);

  // Replace only the half being written; the other half keeps its pre-edge value.
  always_comb begin
    cnt_wr = cnt_o;
    if (wr_lo_i) cnt_wr = (cnt_wr & ~LO_MASK) | (wdata_ext & LO_MASK);
    if (wr_hi_i) cnt_wr = (cnt_wr & LO_MASK) | ((wdata_ext << DATA_WIDTH) & ~LO_MASK);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_o <= '0;
    end else if (wr_lo_i || wr_hi_i) begin
      cnt_o <= cnt_wr;
    end else if (inc_i) begin
      cnt_o <= cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/exe_csr_unit.sv
// Zicsr execute unit: machine CSR file, mcycle/minstret, returns old CSR value for rd.
// Latency: 1 cycle issue-to-result; back-to-back issue every cycle, each op sees the prior op's write.
// Backpressure: none; an op issued with valid_i is always completed (or dropped by reset).
// Ports: clk_i, rst_n_i (sync active-low), valid_i/inst_i/op1_i issue, retire_i -> minstret,
//        valid_o/reg_we_o/reg_waddr_o/reg_wdata_o/illegal_o result stage.
module exe_csr_unit
  import exe_csr_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    CNT_WIDTH  = 64,
  parameter logic [DATA_WIDTH-1:0] MTVEC_RST  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  input  logic [31:0]           inst_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic                  retire_i,
  output logic                  valid_o,
  output logic                  reg_we_o,
  output logic [4:0]            reg_waddr_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  output logic                  illegal_o
);

  // Upper counter words are only addressable on a 32-bit datapath.
  localparam bit HAS_HI = (DATA_WIDTH == 32) && (CNT_WIDTH > DATA_WIDTH);

  csr_inst_t inst;
  csr_op_e   op;
  logic      use_imm;
  logic      accept;
  logic      hit;
  logic      wr_en;
  logic      illegal;
  logic      csr_wr;

  logic [DATA_WIDTH-1:0] src_val;
  logic [DATA_WIDTH-1:0] old_val;
  logic [DATA_WIDTH-1:0] new_val;

  logic [DATA_WIDTH-1:0] mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [CNT_WIDTH-1:0]  mcycle, minstret;

  assign inst = csr_inst_t'(inst_i);

  always_comb begin
    op      = CSR_OP_NONE;
    use_imm = 1'b0;
    case (inst.funct3)
      INST_CSRRW:  op = CSR_OP_RW;
      INST_CSRRS:  op = CSR_OP_RS;
      INST_CSRRC:  op = CSR_OP_RC;
      INST_CSRRWI: begin op = CSR_OP_RW; use_imm = 1'b1; end
      INST_CSRRSI: begin op = CSR_OP_RS; use_imm = 1'b1; end
      INST_CSRRCI: begin op = CSR_OP_RC; use_imm = 1'b1; end
      default:     op = CSR_OP_NONE;
    endcase
  end

  // funct3==3'b100 is accepted but has no CSR op; it reports illegal.
  assign accept  = valid_i && (inst.opcode == INST_TYPE_SYSTEM) && (inst.funct3 != 3'b000);
  assign src_val = use_imm ? DATA_WIDTH'(inst.rs1) : op1_i;
  // Set/clear with rs1/zimm field zero is a pure read.
  assign wr_en   = (op == CSR_OP_RW) || (inst.rs1 != 5'd0);

  // Combinational read mux; counter reads return the pre-edge value.
  always_comb begin
    old_val = '0;
    hit     = 1'b1;
    case (inst.addr)
      CSR_MSTATUS:             old_val = mstatus_q;
      CSR_MTVEC:               old_val = mtvec_q;
      CSR_MSCRATCH:            old_val = mscratch_q;
      CSR_MEPC:                old_val = mepc_q;
      CSR_MCAUSE:              old_val = mcause_q;
      CSR_MCYCLE, CSR_CYCLE:   old_val = DATA_WIDTH'(mcycle);
      CSR_MINSTRET:            old_val = DATA_WIDTH'(minstret);
      CSR_MCYCLEH, CSR_CYCLEH: begin
        old_val = DATA_WIDTH'(mcycle >> DATA_WIDTH);
        hit     = HAS_HI;
      end
      CSR_MINSTRETH: begin
        old_val = DATA_WIDTH'(minstret >> DATA_WIDTH);
        hit     = HAS_HI;
      end
      default:                 hit = 1'b0;
    endcase
  end

  always_comb begin
    new_val = src_val;
    case (op)
      CSR_OP_RS: new_val = old_val | src_val;
      CSR_OP_RC: new_val = old_val & ~src_val;
      default:   new_val = src_val;
    endcase
  end

  assign illegal = !hit || (op == CSR_OP_NONE) || (wr_en && csr_is_ro(inst.addr));
  assign csr_wr  = accept && !illegal && wr_en;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mstatus_q  <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (csr_wr) begin
      case (inst.addr)
        CSR_MSTATUS:  mstatus_q  <= new_val;
        CSR_MTVEC:    mtvec_q    <= new_val;
        CSR_MSCRATCH: mscratch_q <= new_val;
        CSR_MEPC:     mepc_q     <= {new_val[DATA_WIDTH-1:2], 2'b00};
        CSR_MCAUSE:   mcause_q   <= new_val;
        default:      ;
      endcase
    end
  end

  csr_counter #(.CNT_WIDTH(CNT_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_mcycle (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (1'b1),
    .wr_lo_i (csr_wr && (inst.addr == CSR_MCYCLE)),
    .wr_hi_i (csr_wr && (inst.addr == CSR_MCYCLEH) && HAS_HI),
    .wdata_i (new_val),
    .cnt_o   (mcycle)
  );

  csr_counter #(.CNT_WIDTH(CNT_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_minstret (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (retire_i),
    .wr_lo_i (csr_wr && (inst.addr == CSR_MINSTRET)),
    .wr_hi_i (csr_wr && (inst.addr == CSR_MINSTRETH) && HAS_HI),
    .wdata_i (new_val),
    .cnt_o   (minstret)
  );

  // Single result stage; non-accepted cycles drive a clean all-zero result.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !accept) begin
      valid_o     <= 1'b0;
      reg_we_o    <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
      illegal_o   <= 1'b0;
    end else begin
      valid_o     <= 1'b1;
      reg_we_o    <= !illegal && (inst.rd != 5'd0);
      reg_waddr_o <= inst.rd;
      reg_wdata_o <= illegal ? '0 : old_val;
      illegal_o   <= illegal;
    end
  end

endmodule

// File: tb/tb_exe_csr_unit.sv
// Self-checking bench for exe_csr_unit: directed scenarios plus randomized ops against a reference model.
// Latency: results sampled 1 time unit after the edge ending each issue cycle.
// Backpressure: none; the bench issues every cycle it chooses to.
module tb_exe_csr_unit;

  localparam logic [31:0] MTVEC_INIT = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic [31:0] inst;
  logic [31:0] op1;
  logic        retire;

  logic        valid_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        illegal_o;

  always #5 clk = ~clk;

  exe_csr_unit #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (64),
    .MTVEC_RST  (MTVEC_INIT)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .valid_i     (vld),
    .inst_i      (inst),
    .op1_i       (op1),
    .retire_i    (retire),
    .valid_o     (valid_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_wdata_o (reg_wdata_o),
    .illegal_o   (illegal_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain CSRs keyed by address, counters as 64-bit integers.
  logic [31:0] m_csr [int];
  logic [63:0] m_cycle;
  logic [63:0] m_instret;

  task automatic model_reset();
    m_csr[32'h300] = 32'h0;
    m_csr[32'h305] = MTVEC_INIT;
    m_csr[32'h340] = 32'h0;
    m_csr[32'h341] = 32'h0;
    m_csr[32'h342] = 32'h0;
    m_cycle   = 64'h0;
    m_instret = 64'h0;
  endtask

  function automatic logic [31:0] csr_inst(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] addr);
    return {addr, rs1, f3, rd, 7'h73};
  endfunction

  // One clock: predict from the current inputs, step, then compare.
  task automatic tick();
    logic [2:0]  f3;
    logic [11:0] a;
    logic [4:0]  z;
    logic [4:0]  rd;
    logic [31:0] old;
    logic [31:0] s;
    logic [31:0] nv;
    logic [63:0] nc;
    logic [63:0] ni;
    bit          mapped, acc, ill, wen, plain;
    f3  = inst[14:12];
    a   = inst[31:20];
    z   = inst[19:15];
    rd  = inst[11:7];
    acc = rst_n && vld && (inst[6:0] == 7'h73) && (f3 != 3'd0);
    mapped = 1'b1;
    plain  = m_csr.exists(int'(a));
    old    = 32'h0;
    if (plain) old = m_csr[int'(a)];
    else begin
      case (a)
        12'hB00, 12'hC00: old = m_cycle[31:0];
        12'hB80, 12'hC80: old = m_cycle[63:32];
        12'hB02:          old = m_instret[31:0];
        12'hB82:          old = m_instret[63:32];
        default:          mapped = 1'b0;
      endcase
    end
    s   = f3[2] ? {27'd0, z} : op1;
    wen = (f3[1:0] == 2'd1) || (z != 5'd0);
    ill = !mapped || (f3[1:0] == 2'd0) || (wen && (a[11:10] == 2'b11));
    case (f3[1:0])
      2'd1:    nv = s;
      2'd2:    nv = old | s;
      default: nv = old & ~s;
    endcase
    nc = m_cycle + 64'd1;
    ni = m_instret + (retire ? 64'd1 : 64'd0);
    if (acc && !ill && wen) begin
      if (plain) m_csr[int'(a)] = (a == 12'h341) ? (nv & 32'hFFFF_FFFC) : nv;
      else begin
        case (a)
          12'hB00: nc = {m_cycle[63:32], nv};
          12'hB80: nc = {nv, m_cycle[31:0]};
          12'hB02: ni = {m_instret[63:32], nv};
          12'hB82: ni = {nv, m_instret[31:0]};
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else begin
      m_cycle   = nc;
      m_instret = ni;
    end
    check_eq("valid_o", valid_o, acc);
    if (acc) begin
      check_eq("reg_we_o", reg_we_o, !ill && (rd != 5'd0));
      check_eq("reg_waddr_o", reg_waddr_o, rd);
      check_eq("reg_wdata_o", reg_wdata_o, ill ? 32'h0 : old);
      check_eq("illegal_o", illegal_o, ill);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [11:0] addr, input logic [31:0] v);
    vld  = 1'b1;
    inst = csr_inst(f3, rd, rs1, addr);
    op1  = v;
    tick();
  endtask

  task automatic idle();
    vld  = 1'b0;
    inst = 32'h0000_0013;
    op1  = 32'h0;
    tick();
  endtask

  logic [11:0] addr_tbl [14] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80,
                                 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'h7FF, 12'h301, 12'hC01};
  logic [2:0]  f3_tbl   [6]  = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

  initial begin
    model_reset();
    rst_n  = 1'b0;
    vld    = 1'b0;
    inst   = 32'h0;
    op1    = 32'h0;
    retire = 1'b0;
    tick();
    tick();
    check_eq("rst_waddr", reg_waddr_o, 5'd0);
    check_eq("rst_wdata", reg_wdata_o, 32'h0);
    check_eq("rst_illegal", illegal_o, 1'b0);
    rst_n = 1'b1;

    // mscratch swap then read-back
    issue(3'd1, 5'd0, 5'd6, 12'h340, 32'h0000_1234);
    issue(3'd1, 5'd5, 5'd6, 12'h340, 32'hDEAD_BEEF);
    check_eq("swap_old", reg_wdata_o, 32'h0000_1234);
    check_eq("swap_we", reg_we_o, 1'b1);
    issue(3'd2, 5'd7, 5'd0, 12'h340, 32'hFFFF_FFFF);
    check_eq("swap_read", reg_wdata_o, 32'hDEAD_BEEF);

    // mstatus set/clear immediate, and rs1=x0 reads without modifying
    issue(3'd6, 5'd1, 5'd8, 12'h300, 32'h0);
    check_eq("rsi_old", reg_wdata_o, 32'h0);
    issue(3'd2, 5'd1, 5'd0, 12'h300, 32'hFFFF_FFFF);
    check_eq("rs_x0_a", reg_wdata_o, 32'h8);
    issue(3'd2, 5'd1, 5'd0, 12'h300, 32'hFFFF_FFFF);
    check_eq("rs_x0_b", reg_wdata_o, 32'h8);
    issue(3'd7, 5'd1, 5'd8, 12'h300, 32'h0);
    check_eq("rci_old", reg_wdata_o, 32'h8);
    issue(3'd2, 5'd1, 5'd0, 12'h300, 32'h0);
    check_eq("rci_after", reg_wdata_o, 32'h0);

    // mepc low bits forced to zero
    issue(3'd1, 5'd0, 5'd3, 12'h341, 32'h8000_0007);
    issue(3'd2, 5'd2, 5'd0, 12'h341, 32'h0);
    check_eq("mepc_align", reg_wdata_o, 32'h8000_0004);

    // mcycle low-half carry into mcycleh
    issue(3'd1, 5'd0, 5'd1, 12'hB80, 32'h0);
    issue(3'd1, 5'd0, 5'd1, 12'hB00, 32'hFFFF_FFFF);
    issue(3'd2, 5'd1, 5'd0, 12'hB00, 32'h0);
    check_eq("mcycle_max", reg_wdata_o, 32'hFFFF_FFFF);
    issue(3'd2, 5'd1, 5'd0, 12'hB00, 32'h0);
    check_eq("mcycle_wrap", reg_wdata_o, 32'h0);
    issue(3'd2, 5'd1, 5'd0, 12'hB80, 32'h0);
    check_eq("mcycleh_carry", reg_wdata_o, 32'h1);

    // illegal accesses leave state alone
    issue(3'd1, 5'd1, 5'd2, 12'hC00, 32'h55);
    check_eq("ro_illegal", illegal_o, 1'b1);
    check_eq("ro_we", reg_we_o, 1'b0);
    check_eq("ro_wdata", reg_wdata_o, 32'h0);
    issue(3'd1, 5'd1, 5'd2, 12'h7FF, 32'h55);
    check_eq("unmapped_illegal", illegal_o, 1'b1);
    issue(3'd2, 5'd1, 5'd0, 12'h340, 32'h0);
    check_eq("mscratch_kept", reg_wdata_o, 32'hDEAD_BEEF);

    // reset beats an in-flight mtvec write
    issue(3'd1, 5'd0, 5'd1, 12'h305, 32'h5555_0000);
    rst_n = 1'b0;
    issue(3'd1, 5'd1, 5'd1, 12'h305, 32'hAAAA_0000);
    check_eq("rst_drop_valid", valid_o, 1'b0);
    rst_n = 1'b1;
    issue(3'd2, 5'd3, 5'd0, 12'hB00, 32'h0);
    check_eq("rst_mcycle", reg_wdata_o, 32'h0);
    issue(3'd2, 5'd3, 5'd0, 12'hB02, 32'h0);
    check_eq("rst_minstret", reg_wdata_o, 32'h0);
    issue(3'd2, 5'd2, 5'd0, 12'h305, 32'h0);
    check_eq("rst_mtvec", reg_wdata_o, MTVEC_INIT);

    // minstret: write on cycle 5 of 10 retiring cycles
    retire = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 5) issue(3'd1, 5'd0, 5'd1, 12'hB02, 32'h0000_1000);
      else idle();
    end
    retire = 1'b0;
    issue(3'd2, 5'd4, 5'd0, 12'hB02, 32'h0);
    check_eq("minstret_plus5", reg_wdata_o, 32'h0000_1005);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  f3;
      logic [4:0]  rs1;
      logic [6:0]  opc;
      rst_n  = ($urandom_range(0, 99) != 0);
      vld    = ($urandom_range(0, 3) != 0);
      retire = 1'($urandom_range(0, 1));
      f3     = f3_tbl[$urandom_range(0, 5)];
      if ($urandom_range(0, 19) == 0) f3 = 3'd0;
      rs1    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom());
      opc    = ($urandom_range(0, 9) == 0) ? 7'h33 : 7'h73;
      inst   = {addr_tbl[$urandom_range(0, 13)], rs1, f3, 5'($urandom()), opc};
      op1    = $urandom();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
